qsys_serial_target: RTL
=======================

QSYS_SERIAL_TARGET -- requirements
Module: qsys_serial_target

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 8: local address width, 1..23.
REQ-002 SHALL have port csi_MCLK_clk, input, 1: clock.
REQ-003 SHALL have port rsi_MRST_reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port sdi, input, 1: serial frame in, MSB first.
REQ-005 SHALL have port sle, input, 1: frame-active strobe from host.
REQ-006 SHALL have port sdo, output, 1: serial response out, MSB first.
REQ-007 SHALL have port srdy, output, 1: response-ready pulse to host.
REQ-008 SHALL have port loc_address, output, ADDRESS_SIZE: local bus address.
REQ-009 SHALL have port loc_writedata, output, 32: local write data.
REQ-010 SHALL have port loc_write, output, 1: local write strobe.
REQ-011 SHALL have port loc_read, output, 1: local read strobe.
REQ-012 SHALL have port loc_readdata, input, 32: local read data.
REQ-013 SHALL have port loc_waitrequest, input, 1: local stall.
REQ-014 SHALL have port frame_err_count, output, 8: saturating count of aborted frames.

Function
REQ-015 SHALL decode the 64-bit request frame as: [63] 1=write/0=read; [62] parity; [61:32+ADDRESS_SIZE] ignored; [32+ADDRESS_SIZE-1:32] address; [31:0] write data.
REQ-016 SHALL implement states IDLE, SHIFT_IN, EXEC, RESPOND, SHIFT_OUT.
REQ-017 SHALL, in IDLE with sle=1, capture sdi as bit 63, set bit count to 1, and enter SHIFT_IN.
REQ-018 SHALL, in SHIFT_IN, shift in one sdi bit per clock while sle=1, and enter EXEC on the clock that captures the 64th bit.
REQ-019 SHALL, when sle=0 in SHIFT_IN before 64 bits, discard the frame, return to IDLE, and increment frame_err_count, saturating at 255.
REQ-020 SHALL, in EXEC, drive loc_address and loc_writedata from the frame, and assert exactly one of loc_write or loc_read until the first clock with loc_waitrequest=0, then enter RESPOND.
REQ-021 SHALL capture loc_readdata on the read-completing clock (loc_waitrequest=0).
REQ-022 SHALL, in RESPOND, load the response frame and assert srdy for exactly one clock, then enter SHIFT_OUT.
REQ-023 SHALL format the response frame as: [63]=1 ack; [62]=parity error flag; address at [32+ADDRESS_SIZE-1:32]; other high bits 0; [31:0]=read data (read) or echoed write data (write).
REQ-024 SHALL, in SHIFT_OUT, present the response MSB first on sdo, one bit per clock starting the clock after srdy, for 64 clocks, then return to IDLE.
REQ-025 SHALL hold sdo=0 outside SHIFT_OUT.
REQ-026 SHALL ignore sle and sdi in EXEC, RESPOND and SHIFT_OUT.
REQ-027 SHALL give minimum request-to-response latency of 64 shift clocks + 1 EXEC clock + 1 RESPOND clock with zero wait states.

Reset
REQ-028 SHALL, on reset at any time including mid-frame or mid-access, force state IDLE, clear shift register and bit count, and set sdo=0, srdy=0, loc_write=0, loc_read=0, loc_address=0, loc_writedata=0, frame_err_count=0.

Configuration
REQ-029 SHALL, with macro QSYS_SERIAL_TARGET_PARITY_EN defined, check frame bit 62 as even parity over bits [63] and [61:0]; on mismatch it SHALL skip the local access, go EXEC->RESPOND in one clock, and set response bit 62=1 with data 0.
REQ-030 SHALL, without QSYS_SERIAL_TARGET_PARITY_EN, ignore bit 62 and always return response bit 62=0.

Verification
REQ-031 SHALL cover write: frame 0x8000_0012_DEAD_BEEF with zero wait -> loc_write one clock at addr 0x12, data 0xDEADBEEF; srdy one clock; sdo returns 0x8000_0012_DEAD_BEEF (parity bit per config).
REQ-032 SHALL cover read with 3 wait states: read addr 0x05, loc_readdata=0x1234_5678 -> loc_read held 4 clocks; response data 0x12345678.
REQ-033 SHALL cover abort: sle dropped after 20 bits -> no local strobe, no srdy, frame_err_count=1; next full frame completes normally.
REQ-034 SHALL cover saturation: 256 aborted frames -> frame_err_count=255.
REQ-035 SHALL cover mid-SHIFT_OUT reset: all outputs return to reset values; a following frame completes normally.
REQ-036 SHALL cover parity with QSYS_SERIAL_TARGET_PARITY_EN: bad-parity write -> no loc_write, response bit62=1, data 0.

Source files
------------

// File: rtl/qsys_serial_target.sv
// qsys_serial_target: serial-to-local-bus bridge target.
// A host shifts a 64-bit request frame in on sdi (MSB first) while holding sle.
// The target performs one local write or read, pulses srdy, then shifts the
// 64-bit response out on sdo (MSB first), one bit per clock.
//
// Optional feature macro: QSYS_SERIAL_TARGET_PARITY_EN
//   defined   - frame bit 62 is checked as even parity over bits 63 and 61:0.
//               A bad frame skips the local access and is answered with
//               response bit 62 = 1 and data 0.
//   undefined - bit 62 is ignored and response bit 62 is always 0.
//
// Ports:
//   csi_MCLK_clk     clock
//   rsi_MRST_reset   asynchronous active-high reset
//   sdi, sle         serial request data and frame-active strobe
//   sdo, srdy        serial response data and response-ready pulse
//   loc_address      local address (ADDRESS_SIZE bits)
//   loc_writedata    local write data
//   loc_write        local write strobe
//   loc_read         local read strobe
//   loc_readdata     local read data
//   loc_waitrequest  local stall
//   frame_err_count  saturating count of aborted request frames
module qsys_serial_target #(
  parameter int unsigned ADDRESS_SIZE = 8
) (
  input  logic                    csi_MCLK_clk,
  input  logic                    rsi_MRST_reset,
  input  logic                    sdi,
  input  logic                    sle,
  output logic                    sdo,
  output logic                    srdy,
  output logic [ADDRESS_SIZE-1:0] loc_address,
  output logic [31:0]             loc_writedata,
  output logic                    loc_write,
  output logic                    loc_read,
  input  logic [31:0]             loc_readdata,
  input  logic                    loc_waitrequest,
  output logic [7:0]              frame_err_count
);

  localparam int unsigned FRAME_W = 64;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned ERR_W   = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SHIFT_IN  = 3'd1;
  localparam logic [2:0] ST_EXEC      = 3'd2;
  localparam logic [2:0] ST_RESPOND   = 3'd3;
  localparam logic [2:0] ST_SHIFT_OUT = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [FRAME_W-1:0]      shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    perr_q, perr_d;
  logic                    sdo_d, srdy_d;
  logic [ADDRESS_SIZE-1:0] addr_d;
  logic [DATA_W-1:0]       wdata_d;
  logic                    write_d, read_d;
  logic [ERR_W-1:0]        err_d;

  logic [FRAME_W-1:0]      frame_in_c;
  logic [FRAME_W-1:0]      resp_c;
  logic                    perr_in_c;

  // Request frame as it will look once the current sdi bit is shifted in.
  assign frame_in_c = {shreg_q[FRAME_W-2:0], sdi};

  // Even parity over the whole frame: any odd count of ones is an error.
`ifdef QSYS_SERIAL_TARGET_PARITY_EN
  assign perr_in_c = ^frame_in_c;
`else
  assign perr_in_c = 1'b0;
`endif

  // Response frame; loc_readdata is taken on the clock that ends EXEC.
  always_comb begin
    resp_c                        = '0;
    resp_c[FRAME_W-1]             = 1'b1;
    resp_c[FRAME_W-2]             = perr_q;
    resp_c[DATA_W +: ADDRESS_SIZE] = loc_address;
    if (!perr_q) begin
      resp_c[DATA_W-1:0] = shreg_q[FRAME_W-1] ? loc_writedata : loc_readdata;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    sdo_d   = 1'b0;
    srdy_d  = 1'b0;
    addr_d  = loc_address;
    wdata_d = loc_writedata;
    write_d = 1'b0;
    read_d  = 1'b0;
    err_d   = frame_err_count;

    case (state_q)
      ST_IDLE: begin
        if (sle) begin
          shreg_d = {{(FRAME_W-1){1'b0}}, sdi};
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT_IN;
        end
      end

      ST_SHIFT_IN: begin
        if (!sle) begin
          state_d = ST_IDLE;
          shreg_d = '0;
          cnt_d   = '0;
          if (frame_err_count != {ERR_W{1'b1}}) begin
            err_d = frame_err_count + ERR_W'(1);
          end
        end else begin
          shreg_d = frame_in_c;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            // 64th bit: launch the local access in the same edge.
            state_d = ST_EXEC;
            cnt_d   = '0;
            perr_d  = perr_in_c;
            addr_d  = frame_in_c[DATA_W +: ADDRESS_SIZE];
            wdata_d = frame_in_c[DATA_W-1:0];
            write_d = !perr_in_c && frame_in_c[FRAME_W-1];
            read_d  = !perr_in_c && !frame_in_c[FRAME_W-1];
          end
        end
      end

      ST_EXEC: begin
        if (perr_q || !loc_waitrequest) begin
          state_d = ST_RESPOND;
          srdy_d  = 1'b1;
          shreg_d = resp_c;
        end else begin
          write_d = loc_write;
          read_d  = loc_read;
        end
      end

      ST_RESPOND: begin
        state_d = ST_SHIFT_OUT;
        sdo_d   = shreg_q[FRAME_W-1];
        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
        cnt_d   = CNT_W'(1);
      end

      ST_SHIFT_OUT: begin
        // cnt_q counts response bits already presented on sdo.
        if (cnt_q == CNT_W'(FRAME_W)) begin
          state_d = ST_IDLE;
          shreg_d = '0;
          cnt_d   = '0;
          perr_d  = 1'b0;
        end else begin
          sdo_d   = shreg_q[FRAME_W-1];
          shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state_q         <= ST_IDLE;
      shreg_q         <= '0;
      cnt_q           <= '0;
      perr_q          <= 1'b0;
      sdo             <= 1'b0;
      srdy            <= 1'b0;
      loc_address     <= '0;
      loc_writedata   <= '0;
      loc_write       <= 1'b0;
      loc_read        <= 1'b0;
      frame_err_count <= '0;
    end else begin
      state_q         <= state_d;
      shreg_q         <= shreg_d;
      cnt_q           <= cnt_d;
      perr_q          <= perr_d;
      sdo             <= sdo_d;
      srdy            <= srdy_d;
      loc_address     <= addr_d;
      loc_writedata   <= wdata_d;
      loc_write       <= write_d;
      loc_read        <= read_d;
      frame_err_count <= err_d;
    end
  end

endmodule
